// File: rtl/edit_cmd_sequencer.sv
// rtl/edit_cmd_sequencer.sv - button/host command front-end for the hex edit register
// Synchronises and debounces add/del buttons, arbitrates against host loads, enforces edit holdoff.
module edit_cmd_sequencer #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLDOFF_CYC  = 10_000_000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_add,
  input  logic        btn_del,
  input  logic [3:0]  sw_hex,
  input  logic        ld_req,
  input  logic [31:0] ld_data,
  output logic        ld_ack,
  output logic        cmd_add,
  output logic        cmd_del,
  output logic        cmd_set,
  output logic [3:0]  cmd_hex,
  output logic [31:0] cmd_din,
  output logic        busy,
  output logic [7:0]  ev_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  typedef enum logic [1:0] {OP_SET, OP_ADD, OP_DEL} op_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

  // Bit 0 is the add button, bit 1 the delete button.
  logic [1:0]       sync1, sync2, deb, deb_q, pend;
  logic [CNT_W-1:0] db_cnt [2];
  logic [3:0]       hex_s1, hex_s2;
  logic [1:0]       rise;

  state_t           state, state_nxt;
  op_t              op, op_nxt;
  logic             from_hold;
  logic [CNT_W-1:0] hold_cnt;

  assign rise = deb & ~deb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= '0;
      sync2  <= '0;
      hex_s1 <= '0;
      hex_s2 <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= {btn_del, btn_add};
      sync2  <= sync1;
      hex_s1 <= sw_hex;
      hex_s2 <= hex_s1;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (ld_req) begin
          state_nxt = ISSUE;
          op_nxt    = OP_SET;
        end else if (pend[0]) begin
          state_nxt = ISSUE;
          op_nxt    = OP_ADD;
        end else if (pend[1]) begin
          state_nxt = ISSUE;
          op_nxt    = OP_DEL;
        end
      end
      ISSUE: begin
        if (op != OP_SET) state_nxt = HOLD;
        else if (from_hold && hold_cnt < HOLD_LAST) state_nxt = HOLD;
        else state_nxt = IDLE;
      end
      HOLD: begin
        if (ld_req) begin
          state_nxt = ISSUE;
          op_nxt    = OP_SET;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      op        <= OP_SET;
      from_hold <= 1'b0;
      hold_cnt  <= '0;
      pend      <= '0;
      cmd_add   <= 1'b0;
      cmd_del   <= 1'b0;
      cmd_set   <= 1'b0;
      ld_ack    <= 1'b0;
      busy      <= 1'b0;
      cmd_hex   <= '0;
      cmd_din   <= '0;
      ev_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      op      <= op_nxt;
      cmd_add <= (state_nxt == ISSUE) && (op_nxt == OP_ADD);
      cmd_del <= (state_nxt == ISSUE) && (op_nxt == OP_DEL);
      cmd_set <= (state_nxt == ISSUE) && (op_nxt == OP_SET);
      ld_ack  <= (state_nxt == ISSUE) && (op_nxt == OP_SET);
      busy    <= (state_nxt != IDLE);
      if (state_nxt == ISSUE) from_hold <= (state == HOLD);
      if (state_nxt == ISSUE && op_nxt == OP_SET) cmd_din <= ld_data;
      if (state_nxt == ISSUE && op_nxt == OP_ADD) cmd_hex <= hex_s2;
      // A load inside holdoff keeps the window running so it ends on schedule.
      if (state == ISSUE && op != OP_SET) begin
        hold_cnt <= '0;
        ev_cnt   <= ev_cnt + 1'b1;
      end else if (state == HOLD || (state == ISSUE && from_hold)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == ISSUE && op == OP_ADD) pend[0] <= 1'b0;
      if (state == ISSUE && op == OP_DEL) pend[1] <= 1'b0;
      if (state == IDLE || (state == ISSUE && op == OP_SET)) begin
        if (rise[0]) pend[0] <= 1'b1;
        else if (rise[1]) pend[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edit_cmd_sequencer.sv
// tb/tb_edit_cmd_sequencer.sv - directed bench for edit_cmd_sequencer
// Timeline model (holdoff windows, stability runs) compared every cycle, plus literal pins.
module tb_edit_cmd_sequencer;
  localparam int DEB = 4;
  localparam int HLD = 16;
  localparam int N   = 2048;

  logic        clk = 1'b0, rstn = 1'b0, btn_add = 1'b0, btn_del = 1'b0, ld_req = 1'b0;
  logic [3:0]  sw_hex = 4'h0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_ack, cmd_add, cmd_del, cmd_set, busy;
  logic [3:0]  cmd_hex;
  logic [31:0] cmd_din;
  logic [7:0]  ev_cnt;

  edit_cmd_sequencer #(.DEBOUNCE_CYC(DEB), .HOLDOFF_CYC(HLD), .CNT_W(24)) dut (
    .clk(clk), .rstn(rstn), .btn_add(btn_add), .btn_del(btn_del), .sw_hex(sw_hex),
    .ld_req(ld_req), .ld_data(ld_data), .ld_ack(ld_ack), .cmd_add(cmd_add),
    .cmd_del(cmd_del), .cmd_set(cmd_set), .cmd_hex(cmd_hex), .cmd_din(cmd_din),
    .busy(busy), .ev_cnt(ev_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int n_add = 0, n_del = 0, n_set = 0, busy_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef enum {M_IDLE, M_SET, M_ADD, M_DEL, M_HOLD} mode_e;
  int          cyc = 0;
  bit          ha [N];
  bit          hd [N];
  bit [3:0]    hs [N];
  bit          deb_a = 0, deb_d = 0, flip_a = 0, flip_d = 0, pend_a = 0, pend_d = 0;
  int          run_a = 0, run_d = 0, win_end = -1;
  mode_e       mode = M_IDLE;
  logic [7:0]  m_ev = 0;
  logic [3:0]  m_hex = 0;
  logic [31:0] m_din = 0;

  always @(posedge clk) begin : model
    bit ra, rd, sa, sd;
    bit [3:0] sh;
    mode_e prev, nxt;
    cyc++;
    if (!rstn) begin
      ha[cyc % N] = 0; hd[cyc % N] = 0; hs[cyc % N] = 0;
      deb_a = 0; deb_d = 0; flip_a = 0; flip_d = 0; pend_a = 0; pend_d = 0;
      run_a = 0; run_d = 0; win_end = -1; mode = M_IDLE;
      m_ev = 0; m_hex = 0; m_din = 0;
    end else begin
      ha[cyc % N] = btn_add; hd[cyc % N] = btn_del; hs[cyc % N] = sw_hex;
      sa = (cyc >= 2) ? ha[(cyc - 2) % N] : 1'b0;
      sd = (cyc >= 2) ? hd[(cyc - 2) % N] : 1'b0;
      sh = (cyc >= 2) ? hs[(cyc - 2) % N] : 4'h0;
      ra = flip_a; rd = flip_d;
      flip_a = 0; flip_d = 0;
      // A level is accepted once it has disagreed for DEB edges in a row.
      if (sa != deb_a) begin
        run_a++;
        if (run_a == DEB) begin deb_a = sa; run_a = 0; flip_a = sa; end
      end else run_a = 0;
      if (sd != deb_d) begin
        run_d++;
        if (run_d == DEB) begin deb_d = sd; run_d = 0; flip_d = sd; end
      end else run_d = 0;
      prev = mode;
      if (prev == M_ADD) begin m_ev++; pend_a = 0; end
      if (prev == M_DEL) begin m_ev++; pend_d = 0; end
      case (prev)
        M_IDLE: begin
          if (ld_req) nxt = M_SET;
          else if (pend_a) nxt = M_ADD;
          else if (pend_d) nxt = M_DEL;
          else nxt = M_IDLE;
        end
        M_HOLD: nxt = ld_req ? M_SET : ((cyc <= win_end) ? M_HOLD : M_IDLE);
        default: nxt = (cyc <= win_end) ? M_HOLD : M_IDLE;
      endcase
      if (nxt == M_SET) m_din = ld_data;
      if (nxt == M_ADD) m_hex = sh;
      if (nxt == M_ADD || nxt == M_DEL) win_end = cyc + HLD;
      if (prev == M_IDLE || prev == M_SET) begin
        if (ra) pend_a = 1;
        else if (rd) pend_d = 1;
      end
      mode = nxt;
    end
    #1;
    check($sformatf("model@%0d", cyc),
          {cmd_add, cmd_del, cmd_set, ld_ack, busy, cmd_hex, ev_cnt, cmd_din},
          {mode == M_ADD, mode == M_DEL, mode == M_SET, mode == M_SET, mode != M_IDLE,
           m_hex, m_ev, m_din});
    n_add += int'(cmd_add); n_del += int'(cmd_del); n_set += int'(cmd_set);
    busy_n += int'(busy);
  end

  task automatic wait_pulse(input string name, output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #2;
      if (cmd_add || cmd_del || cmd_set) begin ok = 1; t = cyc; end
    end
    check({name, "_timeout"}, ok, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #2;
      if (!busy) ok = 1;
    end
    check({name, "_idle_timeout"}, ok, 1'b1);
  endtask

  int a0, d0, s0, b0, t, t_press;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outputs", {cmd_add, cmd_del, cmd_set, ld_ack, busy, cmd_hex, ev_cnt, cmd_din}, 64'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Bouncy add press, then a fresh press landing inside holdoff.
    sw_hex = 4'hA; a0 = n_add; b0 = busy_n;
    for (int k = 0; k < 3; k++) begin
      btn_add = 1'b1; repeat (2) @(negedge clk);
      btn_add = 1'b0; repeat (2) @(negedge clk);
    end
    btn_add = 1'b1;
    wait_pulse("t1", t);
    check("t1_cmd_add", cmd_add, 1'b1);
    check("t1_cmd_hex", cmd_hex, 4'hA);
    @(negedge clk) btn_add = 1'b0;
    repeat (5) @(negedge clk);
    btn_add = 1'b1;
    wait_idle("t1");
    check("t1_one_add", n_add - a0, 1);
    check("t1_ev_cnt", ev_cnt, 8'd1);
    check("t1_busy_cycles", busy_n - b0, 17);
    @(negedge clk) btn_add = 1'b0;
    repeat (10) @(negedge clk);

    a0 = n_add;
    btn_add = 1'b1; t_press = cyc + 1;
    wait_pulse("t2", t);
    check("t2_latency", t - t_press + 1, DEB + 4);
    @(negedge clk) btn_add = 1'b0;
    wait_idle("t2");
    check("t2_ev_cnt", ev_cnt, 8'd2);
    check("t2_one_add", n_add - a0, 1);

    // Delete on its own.
    repeat (8) @(negedge clk);
    sw_hex = 4'h3; d0 = n_del;
    btn_del = 1'b1;
    wait_pulse("del", t);
    check("del_cmd_del", cmd_del, 1'b1);
    @(negedge clk) btn_del = 1'b0;
    wait_idle("del");
    check("del_ev_cnt", ev_cnt, 8'd3);
    check("del_hex_held", cmd_hex, 4'hA);
    check("del_one", n_del - d0, 1);

    // Host load while idle.
    repeat (8) @(negedge clk);
    ld_req = 1'b1; ld_data = 32'hDEADBEEF;
    @(posedge clk); #2;
    check("t3_set_ack", {cmd_set, ld_ack, busy}, 3'b111);
    check("t3_cmd_din", cmd_din, 32'hDEADBEEF);
    @(negedge clk) begin ld_req = 1'b0; ld_data = 32'h0; end
    @(posedge clk); #2;
    check("t3_back_idle", {cmd_set, ld_ack, busy}, 3'b000);
    check("t3_ev_unchanged", ev_cnt, 8'd3);

    // Load at holdoff count 5 must not stretch the busy window.
    repeat (3) @(negedge clk);
    sw_hex = 4'h5; b0 = busy_n;
    btn_add = 1'b1;
    wait_pulse("t4", t);
    @(negedge clk) btn_add = 1'b0;
    repeat (6) @(negedge clk);
    ld_req = 1'b1; ld_data = 32'h12345678;
    @(posedge clk); #2;
    check("t4_set_in_hold", {cmd_set, ld_ack, busy}, 3'b111);
    check("t4_cmd_din", cmd_din, 32'h12345678);
    @(negedge clk) ld_req = 1'b0;
    wait_idle("t4");
    check("t4_busy_cycles", busy_n - b0, 17);
    check("t4_ev_cnt", ev_cnt, 8'd4);
    check("t4_cmd_hex", cmd_hex, 4'h5);

    // Simultaneous add and delete: add wins, delete is dropped.
    repeat (10) @(negedge clk);
    a0 = n_add; d0 = n_del;
    btn_add = 1'b1; btn_del = 1'b1;
    wait_pulse("t5", t);
    check("t5_add_not_del", {cmd_add, cmd_del}, 2'b10);
    @(negedge clk) begin btn_add = 1'b0; btn_del = 1'b0; end
    wait_idle("t5");
    repeat (10) @(negedge clk);
    check("t5_adds", n_add - a0, 1);
    check("t5_dels", n_del - d0, 0);
    check("t5_ev_cnt", ev_cnt, 8'd5);

    // Asynchronous reset in the middle of holdoff.
    sw_hex = 4'h7;
    btn_add = 1'b1;
    wait_pulse("t6", t);
    @(negedge clk) btn_add = 1'b0;
    repeat (9) @(posedge clk);
    #2 check("t6_busy_before", busy, 1'b1);
    #1 rstn = 1'b0;
    #1 check("t6_async_clear", {cmd_add, cmd_del, cmd_set, ld_ack, busy, cmd_hex, ev_cnt, cmd_din}, 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    a0 = n_add; d0 = n_del; s0 = n_set;
    repeat (50) @(negedge clk);
    check("t6_no_pulse", (n_add - a0) + (n_del - d0) + (n_set - s0), 0);
    check("t6_ev_cnt", ev_cnt, 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
